// File: rtl/ftdnn_pkg.sv
// Shared widths, types and the requantization helper for the partial-sum datapath.
package ftdnn_pkg;

    localparam int WID_PSUM        = 32;
    localparam int WID_PSUMADDR    = 9;
    localparam int WID_ACT         = 16;
    localparam int WID_SHAMT       = $clog2(WID_PSUM);
    localparam int PSUM_RD_LAT     = 2;
    localparam int PSUM_FIFO_DEPTH = 4;

    localparam int ACT_MAX = (1 << (WID_ACT - 1)) - 1;
    localparam int ACT_MIN = -(1 << (WID_ACT - 1));

    typedef logic signed [WID_PSUM-1:0] psum_t;
    typedef logic signed [WID_ACT-1:0]  act_t;

    typedef struct packed {
        psum_t hi;
        psum_t lo;
    } psum_pair_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } drain_state_e;

    // Floor-rounded arithmetic shift, then clamp into the signed activation range.
    function automatic act_t requant(input psum_t p, input logic [WID_SHAMT-1:0] sh);
        psum_t r;
        r = p >>> sh;
        if (r > psum_t'(ACT_MAX)) begin
            return act_t'(ACT_MAX);
        end else if (r < psum_t'(ACT_MIN)) begin
            return act_t'(ACT_MIN);
        end
        return act_t'(r);
    endfunction

endpackage

// File: rtl/psum_drain_if.sv
// Buffer read port plus the activation output stream of the partial-sum drain engine.
interface psum_drain_if;
    import ftdnn_pkg::*;

    logic [WID_PSUMADDR-1:0] psum_rd_addr;
    logic                    psum_rd_en;
    logic [2*WID_PSUM-1:0]   psum_rd_data;

    // Stream handshake: a beat transfers on a cycle where out_valid & out_ready;
    // while out_valid is high and out_ready low, out_data/out_last hold stable.
    act_t                    out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;

    modport master (
        output psum_rd_addr, psum_rd_en,
        input  psum_rd_data,
        output out_data, out_valid, out_last,
        input  out_ready
    );

    modport slave (
        input  psum_rd_addr, psum_rd_en,
        output psum_rd_data,
        input  out_data, out_valid, out_last,
        output out_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered-pointer head, occupancy count and flags.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk_l,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_l) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psum_drain.sv
// Walks a psum buffer address range, lands read data in a small FIFO and streams
// each word out as two requantized activations (low half, then high half).
module psum_drain
    import ftdnn_pkg::*;
#(
    parameter int RD_LAT     = PSUM_RD_LAT,
    parameter int FIFO_DEPTH = PSUM_FIFO_DEPTH
) (
    input  logic                    clk_l,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WID_PSUMADDR-1:0] base_addr,
    input  logic [WID_PSUMADDR:0]   num_words,
    input  logic [WID_SHAMT-1:0]    shamt,
    output logic                    busy,
    output logic                    done,
    output drain_state_e            state_dbg,
    psum_drain_if.master            bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OUT_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

    drain_state_e            state_q;
    drain_state_e            state_d;
    logic [WID_PSUMADDR:0]   num_q;
    logic [WID_PSUMADDR:0]   issued_q;
    logic [WID_PSUMADDR:0]   words_out_q;
    logic [WID_SHAMT-1:0]    shamt_q;
    logic [WID_PSUMADDR-1:0] rd_addr_q;
    logic                    rd_en_q;
    logic [RD_LAT-1:0]       lat_q;
    logic                    half_q;

    logic                    issue;
    logic                    credit_ok;
    logic                    push;
    logic                    pop;
    logic                    accept;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [CNT_W-1:0]        fifo_count;
    logic [2*WID_PSUM-1:0]   fifo_head_raw;
    psum_pair_t              head_word;
    psum_t                   half_psum;
    logic [OUT_W-1:0]        outstanding;

    // Every read still in the latency pipe already owns a FIFO slot.
    assign outstanding = OUT_W'(fifo_count) + OUT_W'(rd_en_q) + OUT_W'($countones(lat_q));
    assign credit_ok   = !fifo_full && (outstanding < OUT_W'(FIFO_DEPTH));
    assign push        = lat_q[RD_LAT-1];

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        state_d = ST_ISSUE;
                        issue   = 1'b1;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_ISSUE: begin
                if (issued_q == num_q) begin
                    state_d = ST_DRAIN;
                end else if (credit_ok) begin
                    issue = 1'b1;
                    if (issued_q + (WID_PSUMADDR+1)'(1) == num_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!rd_en_q && (lat_q == '0) && fifo_empty) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            num_q       <= '0;
            issued_q    <= '0;
            words_out_q <= '0;
            shamt_q     <= '0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            lat_q       <= '0;
            half_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_en_q <= issue;
            lat_q   <= {lat_q[RD_LAT-2:0], rd_en_q};
            if (state_q == ST_IDLE && start) begin
                num_q       <= num_words;
                shamt_q     <= shamt;
                words_out_q <= '0;
                half_q      <= 1'b0;
                rd_addr_q   <= base_addr;
                issued_q    <= issue ? (WID_PSUMADDR+1)'(1) : '0;
            end else begin
                if (issue) begin
                    rd_addr_q <= rd_addr_q + WID_PSUMADDR'(1);
                    issued_q  <= issued_q + (WID_PSUMADDR+1)'(1);
                end
                if (accept) begin
                    half_q <= ~half_q;
                end
                if (pop) begin
                    words_out_q <= words_out_q + (WID_PSUMADDR+1)'(1);
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (2*WID_PSUM),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_l     (clk_l),
        .rst       (rst),
        .push      (push),
        .push_data (bus.psum_rd_data),
        .pop       (pop),
        .head      (fifo_head_raw),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // An empty FIFO lets the word arriving this cycle present its low half directly.
    assign head_word = fifo_empty ? psum_pair_t'(bus.psum_rd_data) : psum_pair_t'(fifo_head_raw);
    assign half_psum = half_q ? head_word.hi : head_word.lo;

    assign busy          = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done          = (state_q == ST_FIN);
    assign state_dbg     = state_q;
    assign bus.out_valid = busy && (!fifo_empty || push);
    assign bus.out_data  = bus.out_valid ? requant(half_psum, shamt_q) : '0;
    assign bus.out_last  = bus.out_valid && half_q &&
                           (words_out_q == num_q - (WID_PSUMADDR+1)'(1));
    assign accept        = bus.out_valid && bus.out_ready;
    assign pop           = accept && half_q;

    assign bus.psum_rd_addr = rd_addr_q;
    assign bus.psum_rd_en   = rd_en_q;

endmodule
